// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package sseg_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [3:0] DIGIT_EN [0:3] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0011000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Valid/ready port carrying new display contents into the scan controller.
interface sseg_scan_ctrl_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_value;
    logic [3:0]  upd_dp;
    logic [3:0]  upd_blank;

    modport master (
        output upd_valid,
        output upd_value,
        output upd_dp,
        output upd_blank,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_value,
        input  upd_dp,
        input  upd_blank,
        output upd_ready
    );
endinterface

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment pattern {g..a}.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Full 16-entry hex glyph table
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0:    seg = SEG_HEX_0;
            4'h1:    seg = SEG_HEX_1;
            4'h2:    seg = SEG_HEX_2;
            4'h3:    seg = SEG_HEX_3;
            4'h4:    seg = SEG_HEX_4;
            4'h5:    seg = SEG_HEX_5;
            4'h6:    seg = SEG_HEX_6;
            4'h7:    seg = SEG_HEX_7;
            4'h8:    seg = SEG_HEX_8;
            4'h9:    seg = SEG_HEX_9;
            4'hA:    seg = SEG_HEX_A;
            4'hB:    seg = SEG_HEX_B;
            4'hC:    seg = SEG_HEX_C;
            4'hD:    seg = SEG_HEX_D;
            4'hE:    seg = SEG_HEX_E;
            4'hF:    seg = SEG_HEX_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit common-anode scan controller with blanking gaps and
// frame-aligned double-buffered content updates.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    M_CLOCK,
    input  logic                    RESET,
    input  logic                    en,
    sseg_scan_ctrl_if.slave         upd,
    output logic [3:0]              IO_SSEGD,
    output logic [7:0]              IO_SSEG,
    output logic                    frame_tick
);

    localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 32'sd1);

    scan_state_t      state_r, state_s;
    logic [1:0]       dig_r, dig_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             boundary_s;

    logic [15:0]      act_value_r, sh_value_r;
    logic [3:0]       act_dp_r, sh_dp_r;
    logic [3:0]       act_blank_r, sh_blank_r;
    logic             pending_r;
    logic             ready_r;
    logic             xfer_s;

    logic [1:0]       sel_s;
    logic [3:0]       nib_s;
    logic [6:0]       hex_seg_s;
    logic [3:0]       ssegd_s;
    logic [7:0]       seg_s;

    assign upd.upd_ready = ready_r;
    assign xfer_s        = upd.upd_valid & ready_r;

    // Next scan position; en low parks the scan in OFF from any state
    always_comb begin
        state_s    = state_r;
        dig_s      = dig_r;
        cnt_s      = cnt_r;
        boundary_s = 1'b0;
        if (!en) begin
            state_s = OFF;
            dig_s   = 2'd0;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                OFF: begin
                    state_s = GAP;
                    dig_s   = 2'd0;
                    cnt_s   = CNT_ZERO;
                end
                GAP: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_s = SHOW;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                SHOW: begin
                    if (cnt_r == DIGIT_LAST) begin
                        state_s    = GAP;
                        dig_s      = dig_r + 2'd1;
                        cnt_s      = CNT_ZERO;
                        boundary_s = (dig_r == 2'd3);
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = OFF;
                    dig_s   = 2'd0;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Digit 0 lives in the most-significant nibble and bit 3 of dp/blank
    assign sel_s = 2'd3 - dig_s;

    // Select the active nibble for the digit about to be shown
    always_comb begin
        nib_s = 4'h0;
        case (dig_s)
            2'd0:    nib_s = act_value_r[15:12];
            2'd1:    nib_s = act_value_r[11:8];
            2'd2:    nib_s = act_value_r[7:4];
            2'd3:    nib_s = act_value_r[3:0];
            default: nib_s = 4'h0;
        endcase
    end

    hex_to_sseg u_hex (
        .nibble (nib_s),
        .seg    (hex_seg_s)
    );

    // Pin values derived from the next state so pins switch with the state
    always_comb begin
        ssegd_s = 4'b1111;
        seg_s   = 8'hFF;
        if (state_s == SHOW) begin
            ssegd_s = DIGIT_EN[dig_s];
            if (act_blank_r[sel_s]) begin
                seg_s = 8'hFF;
            end else begin
                seg_s = {~act_dp_r[sel_s], hex_seg_s};
            end
        end else begin
            ssegd_s = 4'b1111;
            seg_s   = 8'hFF;
        end
    end

    // Scan FSM, registered pins and the shadow/active content buffers
    always_ff @(posedge M_CLOCK) begin
        if (RESET) begin
            state_r     <= OFF;
            dig_r       <= 2'd0;
            cnt_r       <= CNT_ZERO;
            frame_tick  <= 1'b0;
            IO_SSEGD    <= 4'b1111;
            IO_SSEG     <= 8'hFF;
            act_value_r <= 16'h0000;
            act_dp_r    <= 4'b0000;
            act_blank_r <= 4'b1111;
            sh_value_r  <= 16'h0000;
            sh_dp_r     <= 4'b0000;
            sh_blank_r  <= 4'b0000;
            pending_r   <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            dig_r      <= dig_s;
            cnt_r      <= cnt_s;
            frame_tick <= boundary_s;
            IO_SSEGD   <= ssegd_s;
            IO_SSEG    <= seg_s;
            // A transfer needs pending low, so it never collides with a swap
            if (boundary_s && pending_r) begin
                act_value_r <= sh_value_r;
                act_dp_r    <= sh_dp_r;
                act_blank_r <= sh_blank_r;
                pending_r   <= 1'b0;
                ready_r     <= 1'b1;
            end else if (xfer_s) begin
                sh_value_r <= upd.upd_value;
                sh_dp_r    <= upd.upd_dp;
                sh_blank_r <= upd.upd_blank;
                pending_r  <= 1'b1;
                ready_r    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl (DIGIT_CYCLES=4, BLANK_CYCLES=2) with a
// frame-position model checked every cycle plus literal spot checks.
module tb_sseg_scan_ctrl;

    localparam int DC    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = DC + BC;
    localparam int FRAME = 4 * SLOT;

    logic       clk;
    logic       RESET;
    logic       en;
    logic [3:0] IO_SSEGD;
    logic [7:0] IO_SSEG;
    logic       frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    sseg_scan_ctrl_if bus ();

    sseg_scan_ctrl #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .M_CLOCK    (clk),
        .RESET      (RESET),
        .en         (en),
        .upd        (bus),
        .IO_SSEGD   (IO_SSEGD),
        .IO_SSEG    (IO_SSEG),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] hex_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: scan position is elapsed time since the scan (re)started
    bit          run = 0;
    int          t = 0;
    logic [15:0] m_act_v, m_sh_v;
    logic [3:0]  m_act_dp, m_sh_dp, m_act_bl, m_sh_bl;
    bit          m_pend;

    initial begin
        bit          r, e, v, pold, tick;
        logic [15:0] uv;
        logic [3:0]  udp, ubl, ex_d, onehot;
        logic [7:0]  ex_s;
        int          p, d;
        logic [3:0]  nib;
        forever begin
            @(posedge clk);
            r = RESET; e = en; v = bus.upd_valid;
            uv = bus.upd_value; udp = bus.upd_dp; ubl = bus.upd_blank;
            tick = 0;
            if (r) begin
                run = 0; t = 0;
                m_act_v = 16'h0; m_act_dp = 4'h0; m_act_bl = 4'hF;
                m_sh_v = 16'h0; m_sh_dp = 4'h0; m_sh_bl = 4'h0;
                m_pend = 0;
            end else begin
                pold = m_pend;
                if (!e) run = 0;
                else if (!run) begin run = 1; t = 0; end
                else begin t++; tick = (t % FRAME == 0); end
                if (tick && pold) begin
                    m_act_v = m_sh_v; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl; m_pend = 0;
                end
                if (v && !pold) begin
                    m_sh_v = uv; m_sh_dp = udp; m_sh_bl = ubl; m_pend = 1;
                end
            end
            ex_d = 4'b1111; ex_s = 8'hFF;
            if (!r && run) begin
                p = t % FRAME; d = p / SLOT;
                if ((p % SLOT) >= BC) begin
                    onehot = 4'b1000 >> d;
                    ex_d = ~onehot;
                    nib = 4'((m_act_v >> (4 * (3 - d))) & 16'h000F);
                    ex_s = m_act_bl[3-d] ? 8'hFF : {~m_act_dp[3-d], hex_tbl[nib]};
                end
            end
            #1;
            cmp("model_ssegd", {12'h0, IO_SSEGD}, {12'h0, ex_d});
            cmp("model_sseg", {8'h0, IO_SSEG}, {8'h0, ex_s});
            cmp("model_tick", {15'h0, frame_tick}, {15'h0, tick});
            cmp("model_ready", {15'h0, bus.upd_ready}, {15'h0, ~m_pend});
        end
    end

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input int max);
        bit seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_tick: no frame_tick within %0d cycles", max);
        end
    endtask

    task automatic offer(input logic [15:0] val, input logic [3:0] dp, input logic [3:0] bl);
        bus.upd_valid = 1'b1; bus.upd_value = val; bus.upd_dp = dp; bus.upd_blank = bl;
    endtask

    initial begin
        RESET = 1'b1; en = 1'b0;
        bus.upd_valid = 1'b0; bus.upd_value = 16'h0; bus.upd_dp = 4'h0; bus.upd_blank = 4'h0;
        skip(3);
        cmp("rst_ssegd", {12'h0, IO_SSEGD}, 16'h000F);
        cmp("rst_sseg", {8'h0, IO_SSEG}, 16'h00FF);
        cmp("rst_ready", {15'h0, bus.upd_ready}, 16'h0001);
        cmp("rst_tick", {15'h0, frame_tick}, 16'h0000);
        RESET = 1'b0; en = 1'b1;

        // Dark frames, then a mid-frame update shown from the next frame
        wait_tick(60);
        skip(3);
        offer(16'h1A3F, 4'b0100, 4'b0000);
        skip(1);
        cmp("upd_ready_drop", {15'h0, bus.upd_ready}, 16'h0000);
        bus.upd_valid = 1'b0;
        wait_tick(30);
        cmp("upd_ready_back", {15'h0, bus.upd_ready}, 16'h0001);
        skip(2);
        cmp("d0_en", {12'h0, IO_SSEGD}, 16'h0007);
        cmp("d0_seg", {8'h0, IO_SSEG}, 16'h00F9);
        skip(6);
        cmp("d1_en", {12'h0, IO_SSEGD}, 16'h000B);
        cmp("d1_seg_dp", {8'h0, IO_SSEG}, 16'h0008);
        skip(6);
        cmp("d2_seg", {8'h0, IO_SSEG}, 16'h00B0);
        skip(6);
        cmp("d3_en", {12'h0, IO_SSEGD}, 16'h000E);
        cmp("d3_seg", {8'h0, IO_SSEG}, 16'h008E);

        // Back-to-back updates: second stalls until the boundary
        offer(16'h1111, 4'h0, 4'h0);
        skip(1);
        bus.upd_value = 16'h2222;
        wait_tick(30);
        skip(1);
        bus.upd_valid = 1'b0;
        skip(1);
        cmp("b2b_first", {8'h0, IO_SSEG}, 16'h00F9);
        wait_tick(30);
        skip(2);
        cmp("b2b_second", {8'h0, IO_SSEG}, 16'h00A4);

        // Handshake exactly on the boundary edge: applied one frame later
        skip(FRAME - 3);
        offer(16'h4567, 4'h0, 4'h0);
        skip(1);
        cmp("edge_tick", {15'h0, frame_tick}, 16'h0001);
        cmp("edge_ready", {15'h0, bus.upd_ready}, 16'h0000);
        bus.upd_valid = 1'b0;
        skip(2);
        cmp("edge_old", {8'h0, IO_SSEG}, 16'h00A4);
        wait_tick(30);
        skip(2);
        cmp("edge_new", {8'h0, IO_SSEG}, 16'h0099);

        // en dropped during digit 2 with an update pending
        offer(16'h89AB, 4'h0, 4'h0);
        skip(1);
        bus.upd_valid = 1'b0;
        skip(12);
        en = 1'b0;
        skip(1);
        cmp("en_off_ssegd", {12'h0, IO_SSEGD}, 16'h000F);
        cmp("en_off_sseg", {8'h0, IO_SSEG}, 16'h00FF);
        cmp("en_off_pend", {15'h0, bus.upd_ready}, 16'h0000);
        skip(3);
        en = 1'b1;
        wait_tick(40);
        skip(2);
        cmp("en_resume", {8'h0, IO_SSEG}, 16'h0080);

        // Reset mid-SHOW discards the pending update
        offer(16'hCDEF, 4'h0, 4'h0);
        skip(1);
        bus.upd_valid = 1'b0;
        skip(5);
        RESET = 1'b1;
        skip(1);
        cmp("mrst_ssegd", {12'h0, IO_SSEGD}, 16'h000F);
        cmp("mrst_sseg", {8'h0, IO_SSEG}, 16'h00FF);
        cmp("mrst_ready", {15'h0, bus.upd_ready}, 16'h0001);
        RESET = 1'b0;
        wait_tick(40);
        skip(2);
        cmp("mrst_en", {12'h0, IO_SSEGD}, 16'h0007);
        cmp("mrst_dark", {8'h0, IO_SSEG}, 16'h00FF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit, common-anode seven-segment display on the IO board.
- Drives IO_SSEGD and IO_SSEG so that all four digits appear lit at once. Inserts an all-off gap between digits to suppress ghosting.
- Accepts new display contents through a valid/ready port. Updates are double-buffered and applied only at frame boundaries, so the display never tears mid-frame.
- Sits between the top-level IO wrapper and any producer of hex values, such as an adder result or counter.

Parameters:
- DIGIT_CYCLES, 50000: clocks each digit stays enabled (1 ms at 50 MHz); must be ≥1.
- BLANK_CYCLES, 500: clocks of all-off gap before each digit; must be ≥1.

Ports:
- M_CLOCK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- en  in  1  scan enable; 0 forces display dark.
- upd_valid  in  1  producer offers new contents.
- upd_ready  out  1  controller can accept contents (no update pending).
- upd_value  in  16  four hex nibbles; [15:12] is digit 0 (leftmost).
- upd_dp  in  4  per-digit decimal point, active-high; bit 3 is digit 0.
- upd_blank  in  4  per-digit blank, active-high; bit 3 is digit 0.
- IO_SSEGD  out  4  active-low digit enables; digit 0 = 4'b0111, digit 3 = 4'b1110.
- IO_SSEG  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Interface: one clock, M_CLOCK. RESET is synchronous and active-high.
- FSM states: OFF, GAP, SHOW. Also a 2-bit digit index (dig) and a cycle counter (cnt) wide enough for max(DIGIT_CYCLES, BLANK_CYCLES).
- RESET=1 at a clock edge:
  - state=OFF, dig=0, cnt=0.
  - active value=0, active dp=0, active blank=4'b1111.
  - shadow cleared, pending=0.
  - IO_SSEGD=4'b1111, IO_SSEG=8'hFF, frame_tick=0, upd_ready=1.
- OFF: outputs dark. If en=1, go to GAP with dig=0, cnt=0.
- GAP: outputs dark. cnt counts 0..BLANK_CYCLES-1; at BLANK_CYCLES-1, go to SHOW with cnt=0.
- SHOW:
  - IO_SSEGD has a single 0 at position (3-dig).
  - IO_SSEG = {~dp[3-dig], hex_to_sseg(nibble)}, where nibble is the active-value nibble for dig.
  - If blank[3-dig]=1, IO_SSEG=8'hFF but the digit stays enabled.
  - cnt counts 0..DIGIT_CYCLES-1; at DIGIT_CYCLES-1, go to GAP with dig=dig+1 (wraps 3→0).
- Frame boundary is the SHOW→GAP transition with dig=3:
  - frame_tick=1 for exactly that cycle, registered so it is visible the cycle after the transition edge.
  - If pending=1, active registers take the shadow and pending clears on the same edge.
- en=0 in any state (evaluated each edge, lower priority than RESET): go to OFF, dig=0, cnt=0, no frame_tick. Pending and shadow are retained.
- IO_SSEGD and IO_SSEG are registered from next-state values, so they change on the same edge as the state. No combinational glitches reach pins.
- Update handshake:
  - upd_ready = ~pending, driven from a register.
  - Transfer occurs when upd_valid & upd_ready at a clock edge: shadow takes upd_value, upd_dp and upd_blank, and pending is set.
  - Transfer on the same edge as a frame boundary with pending=0: captured into the shadow only and applied at the next boundary (no bypass).
  - Boundary with pending=1: upd_ready returns to 1 on the following cycle.
- Hex decode covers all 16 values (0–9, A, b, C, d, E, F). Patterns are {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Frame period = 4*(BLANK_CYCLES+DIGIT_CYCLES) clocks.

Decomposition:
- Package sseg_pkg holds:
  - state enum {OFF, GAP, SHOW};
  - SEG_OFF=7'b1111111;
  - DIGIT_EN[0:3] = 0111, 1011, 1101, 1110;
  - hex segment constants.
- One sub-module, hex_to_sseg: combinational 4-bit in, 7-bit active-low out.

Test Plan (DIGIT_CYCLES=4, BLANK_CYCLES=2, frame=24 clocks):
- Reset then en=1, no update → IO_SSEGD cycles 1111×2, 0111×4, 1111×2, 1011×4, …; IO_SSEG=8'hFF throughout (all blanked); frame_tick every 24 clocks.
- Offer upd_value=16'h1A3F, dp=4'b0100, blank=0 mid-frame → upd_ready drops the next cycle. The old (dark) frame completes. The next frame shows digit0=8'hF9, digit1=8'h08 with dp low (bit7=0), digit2=8'hB0, digit3=8'h8E. upd_ready returns to 1 the cycle after the boundary.
- Two updates back-to-back (0x1111, then 0x2222 held valid) → second is stalled until the boundary. Frame N+1 shows 1111 and frame N+2 shows 2222; no frame ever mixes nibbles.
- Update handshake on the exact frame-boundary edge with pending=0 → the current frame keeps the old value and the new value appears one full frame later.
- en dropped during SHOW of digit 2 → next edge gives IO_SSEGD=1111 and IO_SSEG=FF. On en=1, resume at GAP then digit 0; a pending update is preserved and applied at the first boundary.
- RESET asserted mid-SHOW with a pending update → the next edge gives all-off outputs and upd_ready=1. After release, the display stays dark (blank=1111) and the pending update is discarded.
